// File: rtl/match_control_pkg.sv
// Shared types and constants for the multi-player match sequencer.
package match_pkg;

  typedef enum logic [2:0] {
    TITLE       = 3'd0,
    ROUND_RESET = 3'd1,
    PLAY        = 3'd2,
    ROUND_OVER  = 3'd3,
    MATCH_OVER  = 3'd4,
    PAUSED      = 3'd5
  } stage_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_P     = 8'h13;
  localparam int         WIN_CNT_W = 4;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // Four-bit counters used for wins and round number stick at 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/match_control_if.sv
// Bundle between the match sequencer and its environment (USB keys, game logic, graphics).
interface match_control_if #(
  parameter int NUM_PLAYERS = 2
);
  import match_pkg::*;

  localparam int WIN_W = $clog2(NUM_PLAYERS + 1);

  logic                             frame_tick;
  logic [7:0]                       keycode;
  logic [NUM_PLAYERS-1:0]           player_dead;
  stage_t                           stage;
  logic                             game_reset;
  logic                             freeze;
  logic [3:0]                       round_num;
  logic [WIN_W-1:0]                 winner;
  logic [WIN_CNT_W*NUM_PLAYERS-1:0] wins;
  logic                             over;

  modport master (
    output frame_tick, keycode, player_dead,
    input  stage, game_reset, freeze, round_num, winner, wins, over
  );

  modport slave (
    input  frame_tick, keycode, player_dead,
    output stage, game_reset, freeze, round_num, winner, wins, over
  );

endinterface

// File: rtl/keycode_edge.sv
// Registers the HID keycode and pulses for one cycle when it changes to KEY.
module keycode_edge
  import match_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_ENTER
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] keycode,
  output logic       key_go
);

  logic [7:0] key_prev_r;

  // Previous-cycle keycode history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_r <= 8'h00;
    end else begin
      key_prev_r <= keycode;
    end
  end

  assign key_go = (keycode == KEY) && (key_prev_r != KEY);

endmodule

// File: rtl/match_control.sv
// Best-of-N match sequencer: title, round reset, play, round-over hold, match over.
// Optional pause state enabled by defining MATCH_CTRL_PAUSE_EN.
module match_control
  import match_pkg::*;
#(
  parameter int         NUM_PLAYERS   = 2,
  parameter int         ROUNDS_TO_WIN = 3,
  parameter int         OVER_FRAMES   = 120,
  parameter int         RESET_FRAMES  = 2,
  parameter logic [7:0] START_KEY     = KEY_ENTER
) (
  input  logic           Clk,
  input  logic           Reset,
  match_control_if.slave bus
);

  localparam int WIN_W  = $clog2(NUM_PLAYERS + 1);
  localparam int RST_W  = $clog2(RESET_FRAMES + 1);
  localparam int OVR_W  = $clog2(OVER_FRAMES + 1);
  localparam int WINS_W = WIN_CNT_W * NUM_PLAYERS;

  stage_t            stage_r, stage_nx_s;
  logic [RST_W-1:0]  rst_cnt_r, rst_cnt_nx_s;
  logic [OVR_W-1:0]  ovr_cnt_r, ovr_cnt_nx_s;
  logic [3:0]        round_r, round_nx_s;
  logic [WIN_W-1:0]  winner_r, winner_nx_s;
  logic [WINS_W-1:0] wins_r, wins_nx_s;
  logic              game_reset_r, freeze_r, over_r;

  logic              start_go_s;
  logic [7:0]        dead_pad_s;
  logic [3:0]        alive_s;
  logic              match_won_s;

  keycode_edge #(.KEY(START_KEY)) u_start_edge (
    .clk     (Clk),
    .rst_n   (Reset),
    .keycode (bus.keycode),
    .key_go  (start_go_s)
  );

`ifdef MATCH_CTRL_PAUSE_EN
  logic pause_go_s;

  keycode_edge #(.KEY(KEY_P)) u_pause_edge (
    .clk     (Clk),
    .rst_n   (Reset),
    .keycode (bus.keycode),
    .key_go  (pause_go_s)
  );
`endif

  assign dead_pad_s = 8'(bus.player_dead);
  assign alive_s    = 4'(NUM_PLAYERS) - popcount8(dead_pad_s);

  // Any player holding the target number of round wins ends the match
  always_comb begin
    match_won_s = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (wins_r[i*WIN_CNT_W +: WIN_CNT_W] == WIN_CNT_W'(ROUNDS_TO_WIN)) begin
        match_won_s = 1'b1;
      end else begin
        match_won_s = match_won_s;
      end
    end
  end

  // Next-state, counter and score logic
  always_comb begin
    stage_nx_s   = stage_r;
    rst_cnt_nx_s = rst_cnt_r;
    ovr_cnt_nx_s = ovr_cnt_r;
    round_nx_s   = round_r;
    winner_nx_s  = winner_r;
    wins_nx_s    = wins_r;
    case (stage_r)
      TITLE: begin
        if (start_go_s) begin
          wins_nx_s    = '0;
          round_nx_s   = 4'd1;
          winner_nx_s  = '0;
          rst_cnt_nx_s = RST_W'(RESET_FRAMES);
          stage_nx_s   = ROUND_RESET;
        end else begin
          stage_nx_s = TITLE;
        end
      end
      ROUND_RESET: begin
        if (bus.frame_tick) begin
          if (rst_cnt_r != '0) begin
            rst_cnt_nx_s = rst_cnt_r - RST_W'(1);
          end else begin
            rst_cnt_nx_s = rst_cnt_r;
          end
          if (rst_cnt_r == RST_W'(1)) begin
            stage_nx_s = PLAY;
          end else begin
            stage_nx_s = ROUND_RESET;
          end
        end else begin
          stage_nx_s = ROUND_RESET;
        end
      end
      PLAY: begin
`ifdef MATCH_CTRL_PAUSE_EN
        if (pause_go_s) begin
          stage_nx_s = PAUSED;
        end else
`endif
        if (bus.frame_tick && (alive_s <= 4'd1)) begin
          // With a single survivor the loop hits exactly one player; none alive is a draw.
          winner_nx_s = '0;
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if ((alive_s == 4'd1) && !bus.player_dead[i]) begin
              winner_nx_s = WIN_W'(i + 1);
              wins_nx_s[i*WIN_CNT_W +: WIN_CNT_W] = sat_inc4(wins_r[i*WIN_CNT_W +: WIN_CNT_W]);
            end else begin
              wins_nx_s[i*WIN_CNT_W +: WIN_CNT_W] = wins_nx_s[i*WIN_CNT_W +: WIN_CNT_W];
            end
          end
          ovr_cnt_nx_s = OVR_W'(OVER_FRAMES);
          stage_nx_s   = ROUND_OVER;
        end else begin
          stage_nx_s = PLAY;
        end
      end
      ROUND_OVER: begin
        if (bus.frame_tick) begin
          if (ovr_cnt_r != '0) begin
            ovr_cnt_nx_s = ovr_cnt_r - OVR_W'(1);
          end else begin
            ovr_cnt_nx_s = ovr_cnt_r;
          end
          if ((ovr_cnt_r == OVR_W'(1)) && match_won_s) begin
            stage_nx_s = MATCH_OVER;
          end else if (ovr_cnt_r == OVR_W'(1)) begin
            round_nx_s   = sat_inc4(round_r);
            rst_cnt_nx_s = RST_W'(RESET_FRAMES);
            stage_nx_s   = ROUND_RESET;
          end else begin
            stage_nx_s = ROUND_OVER;
          end
        end else begin
          stage_nx_s = ROUND_OVER;
        end
      end
      MATCH_OVER: begin
        if (start_go_s) begin
          stage_nx_s = TITLE;
        end else begin
          stage_nx_s = MATCH_OVER;
        end
      end
`ifdef MATCH_CTRL_PAUSE_EN
      PAUSED: begin
        if (pause_go_s) begin
          stage_nx_s = PLAY;
        end else begin
          stage_nx_s = PAUSED;
        end
      end
`endif
      default: begin
        stage_nx_s = TITLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs decode the next stage so they align with it
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stage_r      <= TITLE;
      rst_cnt_r    <= '0;
      ovr_cnt_r    <= '0;
      round_r      <= 4'd0;
      winner_r     <= '0;
      wins_r       <= '0;
      game_reset_r <= 1'b1;
      freeze_r     <= 1'b0;
      over_r       <= 1'b0;
    end else begin
      stage_r      <= stage_nx_s;
      rst_cnt_r    <= rst_cnt_nx_s;
      ovr_cnt_r    <= ovr_cnt_nx_s;
      round_r      <= round_nx_s;
      winner_r     <= winner_nx_s;
      wins_r       <= wins_nx_s;
      game_reset_r <= (stage_nx_s == TITLE) || (stage_nx_s == ROUND_RESET);
      freeze_r     <= (stage_nx_s == ROUND_OVER) || (stage_nx_s == MATCH_OVER) ||
                      (stage_nx_s == PAUSED);
      over_r       <= (stage_nx_s == MATCH_OVER);
    end
  end

  assign bus.stage      = stage_r;
  assign bus.game_reset = game_reset_r;
  assign bus.freeze     = freeze_r;
  assign bus.round_num  = round_r;
  assign bus.winner     = winner_r;
  assign bus.wins       = wins_r;
  assign bus.over       = over_r;

endmodule

// File: doc/match_control.md
Name: match_control

Overview:
- Multi-player match sequencer; successor to the single-player stage controller.
- Runs a best-of-N match across NUM_PLAYERS players: title screen, round reset, play, round-over hold and match-over.
- Drives the game logic's reset and freeze inputs, plus stage, round and score outputs for the graphics and HEX displays.
- Sits between the USB keycode export, the game/player logic (via player_dead) and graphics.

Parameters:
- NUM_PLAYERS, 2, number of players (2..8).
- ROUNDS_TO_WIN, 3, round wins needed to take the match (1..15).
- OVER_FRAMES, 120, frame ticks the ROUND_OVER state is held.
- RESET_FRAMES, 2, frame ticks game_reset is held in ROUND_RESET (>=1).
- START_KEY, 8'h28, HID keycode (Enter) that starts or advances.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-Clk pulse per video frame (synchronised vs edge).
- keycode  in  8  current USB HID keycode (0 = none).
- player_dead  in  NUM_PLAYERS  bit i = player i dead, level.
- stage  out  3  current state encoding (match_pkg::stage_t).
- game_reset  out  1  reset to the game/player logic, active-high.
- freeze  out  1  game logic holds its state while high.
- round_num  out  4  current round number, 1-based.
- winner  out  WIN_W  last round result: 0 = draw, i+1 = player i (WIN_W = $clog2(NUM_PLAYERS+1)).
- wins  out  4*NUM_PLAYERS  packed win counters; player i at [4i+3:4i].
- over  out  1  high in MATCH_OVER.

Behaviour:
- Async reset: stage=TITLE, game_reset=1, freeze=0, round_num=0, winner=0, wins=0, over=0, timers=0, key history=0.
- All outputs are registered. A state change is visible the cycle after the triggering event.
- Key edge (key_go): keycode==START_KEY this cycle and !=START_KEY the previous cycle. A held key fires once.
- TITLE:
  - game_reset=1.
  - On key_go: clear wins, round_num=1, winner=0, load rst_cnt=RESET_FRAMES, go to ROUND_RESET.
- ROUND_RESET:
  - game_reset=1; keys and player_dead are ignored.
  - rst_cnt decrements on each frame_tick. A frame_tick while rst_cnt==1 moves to PLAY.
- PLAY:
  - game_reset=0. Evaluated only on frame_tick cycles.
  - alive = NUM_PLAYERS - popcount(player_dead).
  - If alive==1: winner = index of the alive player + 1, and that player's win count increments, saturating at 15.
  - If alive==0: draw, winner=0, no counter change.
  - If alive<=1: load ovr_cnt=OVER_FRAMES and go to ROUND_OVER.
  - All players dying on the same frame is a draw.
- ROUND_OVER:
  - game_reset=0, freeze=1.
  - ovr_cnt decrements per frame_tick. On the frame_tick with ovr_cnt==1:
    - If any wins==ROUNDS_TO_WIN: go to MATCH_OVER.
    - Otherwise: round_num+1 (saturating at 15), load rst_cnt, go to ROUND_RESET.
- MATCH_OVER:
  - over=1, freeze=1, game_reset=0.
  - On key_go: go to TITLE. wins and winner are held until TITLE is exited.
- Simultaneous events:
  - key_go and frame_tick in the same cycle: key_go has no effect outside TITLE/MATCH_OVER; frame_tick has no effect in TITLE/MATCH_OVER.
  - player_dead changing on a non-tick cycle is not sampled.
- Reset asserted mid-round: immediate return to reset values; the round is abandoned.
- Counter widths: $clog2(max+1). Counters never underflow; a decrement only happens while the count is nonzero.

Optional Feature:
- Macro: MATCH_CTRL_PAUSE_EN.
- Defined:
  - Adds state PAUSED.
  - An edge on keycode 8'h13 ('P') in PLAY moves to PAUSED. Another 'P' edge returns to PLAY.
  - In PAUSED: freeze=1, game_reset=0, frame_tick ignored, player_dead not evaluated.
- Undefined:
  - The PAUSED state does not exist and 'P' is ignored.
  - freeze is high only in ROUND_OVER and MATCH_OVER.

Decomposition:
- match_pkg holds:
  - stage_t enum (TITLE=0, ROUND_RESET=1, PLAY=2, ROUND_OVER=3, MATCH_OVER=4, PAUSED=5).
  - KEY_ENTER=8'h28 and KEY_P=8'h13.
  - WIN_CNT_W=4.
- One sub-module, keycode_edge:
  - Registers keycode and emits a one-cycle pulse on the transition to a given key.
  - Parameter KEY; instantiated once, or twice with the pause feature.

Test Plan:
- Reset low mid-PLAY -> stage=TITLE, game_reset=1, wins=0, round_num=0 in the same cycle (async).
- Enter held 10 cycles in TITLE -> exactly one transition. game_reset stays 1 for 2 frame_ticks, then stage=PLAY, round_num=1.
- PLAY, player_dead=2'b10 on a tick -> winner=1, wins[3:0]=1, ROUND_OVER. After 120 ticks -> ROUND_RESET, round_num=2.
- PLAY, player_dead 2'b00 to 2'b11 on one tick -> winner=0, wins unchanged, ROUND_OVER.
- Player 1 wins 3 rounds -> after the third hold, stage=MATCH_OVER, over=1, wins[7:4]=3. Enter -> TITLE. Enter again -> wins cleared.
- With MATCH_CTRL_PAUSE_EN: 'P' edge in PLAY -> PAUSED, freeze=1. player_dead=2'b11 on ticks -> no state change. Second 'P' -> PLAY.
